nw_cell_engine: RTL

- Per-cell compute and sweep controller for the Needleman-Wunsch score matrix.
- Walks the interior cells (i,j) from (1,1) to (N,N) in row-major order.
- For each cell it requests the diag/up/left neighbours from the score RAM manager and computes max(diag+s(a,b), up+GAP, left+GAP).
- Returns the result to the score RAM manager as max with the write enables, and optionally emits a traceback direction.

---
 rtl/nw_pkg.sv | 41 ++++
 rtl/nw_cell_engine_max3_sel.sv | 67 ++++++
 rtl/nw_cell_engine.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/nw_pkg.sv
// -----------------------------------------------------------------------------
// nw_pkg
// Shared definitions for the Needleman-Wunsch cell engine: score constants,
// score width and saturation bounds, nucleotide and traceback direction codes,
// and the sweep controller state encoding.
// -----------------------------------------------------------------------------
package nw_pkg;

   // Score arithmetic
   localparam int SCORE_W        = 9;
   localparam int SCORE_MIN      = -256;
   localparam int SCORE_MAX      = 255;
   localparam int MATCH_SCORE    = 1;
   localparam int MISMATCH_SCORE = -1;
   localparam int GAP_SCORE      = -2;

   // Nucleotide encoding of the sequence ROMs
   typedef enum logic [1:0] {
      NUC_A = 2'd0,
      NUC_C = 2'd1,
      NUC_G = 2'd2,
      NUC_T = 2'd3
   } nuc_t;

   // Traceback direction codes
   localparam logic [1:0] DIR_DIAG = 2'd0;
   localparam logic [1:0] DIR_UP   = 2'd1;
   localparam logic [1:0] DIR_LEFT = 2'd2;

   // Sweep controller states
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_CALC  = 3'd3,
      S_WRITE = 3'd4,
      S_NEXT  = 3'd5,
      S_DONE  = 3'd6
   } state_t;

endpackage

// File: rtl/nw_cell_engine_max3_sel.sv
// -----------------------------------------------------------------------------
// max3_sel
// Combinational cell scorer: returns the saturated maximum of
// diag+s(a,b), up+GAP and left+GAP together with the winning direction.
// Ties resolve diag > up > left.
//
// Ports:
//   diag, up, left  in  SCORE_W signed  neighbour scores
//   match           in  1               char_a == char_b
//   max             out SCORE_W signed  saturated best score
//   dir             out 2               winning direction (DIR_DIAG/UP/LEFT)
// -----------------------------------------------------------------------------
module max3_sel
   import nw_pkg::*;
#(
   parameter int MATCH    = MATCH_SCORE,
   parameter int MISMATCH = MISMATCH_SCORE,
   parameter int GAP      = GAP_SCORE
) (
   input  logic signed [SCORE_W-1:0] diag,
   input  logic signed [SCORE_W-1:0] up,
   input  logic signed [SCORE_W-1:0] left,
   input  logic                      match,
   output logic signed [SCORE_W-1:0] max,
   output logic [1:0]                dir
);

   // Two guard bits keep the sums exact before saturation.
   localparam int EXT_W = SCORE_W + 2;

   localparam logic signed [EXT_W-1:0] MATCH_X    = EXT_W'(MATCH);
   localparam logic signed [EXT_W-1:0] MISMATCH_X = EXT_W'(MISMATCH);
   localparam logic signed [EXT_W-1:0] GAP_X      = EXT_W'(GAP);
   localparam logic signed [EXT_W-1:0] SAT_HI     = EXT_W'(SCORE_MAX);
   localparam logic signed [EXT_W-1:0] SAT_LO     = EXT_W'(SCORE_MIN);

   logic signed [EXT_W-1:0] d_sum;
   logic signed [EXT_W-1:0] u_sum;
   logic signed [EXT_W-1:0] l_sum;
   logic signed [EXT_W-1:0] best;

   always_comb begin
      d_sum = {{2{diag[SCORE_W-1]}}, diag} + (match ? MATCH_X : MISMATCH_X);
      u_sum = {{2{up[SCORE_W-1]}},   up}   + GAP_X;
      l_sum = {{2{left[SCORE_W-1]}}, left} + GAP_X;

      if (d_sum >= u_sum && d_sum >= l_sum) begin
         best = d_sum;
         dir  = DIR_DIAG;
      end else if (u_sum >= l_sum) begin
         best = u_sum;
         dir  = DIR_UP;
      end else begin
         best = l_sum;
         dir  = DIR_LEFT;
      end

      if (best > SAT_HI) begin
         max = SAT_HI[SCORE_W-1:0];
      end else if (best < SAT_LO) begin
         max = SAT_LO[SCORE_W-1:0];
      end else begin
         max = best[SCORE_W-1:0];
      end
   end

endmodule

// File: rtl/nw_cell_engine.sv
// -----------------------------------------------------------------------------
// nw_cell_engine
// Per-cell compute and sweep controller for the Needleman-Wunsch score matrix.
// Walks interior cells (1,1)..(N,N) row-major; for each cell it requests the
// diag/up/left neighbours, scores them with max3_sel and hands the result back
// to the score RAM manager with a one-cycle write strobe.
//
// Optional feature (macro NW_TRACEBACK_DIR_EN):
//   defined   - dir is registered with the score; dir_valid pulses with en_ins
//   undefined - dir and dir_valid are tied to zero, no direction register
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-low reset
//   start         in   begin matrix fill (honoured in IDLE only)
//   char_a/char_b in   nucleotides A[i-1], B[j-1]
//   diag/up/left  in   neighbour scores, valid with signal
//   signal        in   one-cycle pulse: neighbours valid
//   i, j          out  current cell index
//   en_read       out  neighbour read request (REQ and WAIT)
//   change_index  out  one-cycle pulse after index advance
//   en_ins, we    out  one-cycle write strobes
//   max           out  cell score, held between writes
//   busy          out  sweep in progress
//   done          out  one-cycle completion pulse
//   dir/dir_valid out  traceback direction and strobe
// -----------------------------------------------------------------------------
module nw_cell_engine
   import nw_pkg::*;
#(
   parameter int N        = 128,
   parameter int BitAddr  = $clog2(N + 1),
   parameter int MATCH    = MATCH_SCORE,
   parameter int MISMATCH = MISMATCH_SCORE,
   parameter int GAP      = GAP_SCORE
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [1:0]                char_a,
   input  logic [1:0]                char_b,
   input  logic signed [SCORE_W-1:0] diag,
   input  logic signed [SCORE_W-1:0] up,
   input  logic signed [SCORE_W-1:0] left,
   input  logic                      signal,
   output logic [BitAddr:0]          i,
   output logic [BitAddr:0]          j,
   output logic                      en_read,
   output logic                      change_index,
   output logic                      en_ins,
   output logic                      we,
   output logic signed [SCORE_W-1:0] max,
   output logic                      busy,
   output logic                      done,
   output logic [1:0]                dir,
   output logic                      dir_valid
);

   localparam logic [BitAddr:0] IDX_ONE = (BitAddr + 1)'(1);
   localparam logic [BitAddr:0] IDX_N   = (BitAddr + 1)'(N);

   state_t state;
   state_t state_next;

   logic signed [SCORE_W-1:0] diag_reg;
   logic signed [SCORE_W-1:0] up_reg;
   logic signed [SCORE_W-1:0] left_reg;
   logic                      match_reg;
   logic signed [SCORE_W-1:0] sel_max;
   logic [1:0]                sel_dir;
   logic                      last_cell;

   assign last_cell = (i == IDX_N) && (j == IDX_N);

   max3_sel #(
      .MATCH    (MATCH),
      .MISMATCH (MISMATCH),
      .GAP      (GAP)
   ) u_max3_sel (
      .diag  (diag_reg),
      .up    (up_reg),
      .left  (left_reg),
      .match (match_reg),
      .max   (sel_max),
      .dir   (sel_dir)
   );

   // State, index and datapath registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         i         <= IDX_ONE;
         j         <= IDX_ONE;
         max       <= '0;
         diag_reg  <= '0;
         up_reg    <= '0;
         left_reg  <= '0;
         match_reg <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            S_IDLE: begin
               if (start) begin
                  i <= IDX_ONE;
                  j <= IDX_ONE;
               end
            end
            S_WAIT: begin
               // Neighbours and chars are captured so the manager and the
               // sequence ROMs are free to move on after the handshake.
               if (signal) begin
                  diag_reg  <= diag;
                  up_reg    <= up;
                  left_reg  <= left;
                  match_reg <= (char_a == char_b);
               end
            end
            S_CALC: max <= sel_max;
            S_WRITE: begin
               // The index moves as WRITE retires, so change_index in NEXT
               // already sees the new (i,j). The final cell keeps (N,N).
               if (!last_cell) begin
                  if (j < IDX_N) begin
                     j <= j + 1'b1;
                  end else begin
                     j <= IDX_ONE;
                     i <= i + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state and strobe decode
   always_comb begin
      state_next   = state;
      en_read      = 1'b0;
      en_ins       = 1'b0;
      we           = 1'b0;
      change_index = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_next = S_REQ;
         end
         S_REQ: begin
            busy       = 1'b1;
            en_read    = 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            busy    = 1'b1;
            en_read = 1'b1;
            if (signal) state_next = S_CALC;
         end
         S_CALC: begin
            busy       = 1'b1;
            state_next = S_WRITE;
         end
         S_WRITE: begin
            busy = 1'b1;
            // Gated by rst so a reset landing on WRITE never commits a cell.
            en_ins     = rst;
            we         = rst;
            state_next = last_cell ? S_DONE : S_NEXT;
         end
         S_NEXT: begin
            busy         = 1'b1;
            change_index = 1'b1;
            state_next   = S_REQ;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

`ifdef NW_TRACEBACK_DIR_EN
   logic [1:0] dir_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         dir_reg <= DIR_DIAG;
      end else if (state == S_CALC) begin
         dir_reg <= sel_dir;
      end
   end

   assign dir       = dir_reg;
   assign dir_valid = (state == S_WRITE) && rst;
`else
   // Direction is computed by the shared scorer but not kept here.
   logic unused_sel_dir;
   assign unused_sel_dir = ^sel_dir;
   assign dir            = 2'b00;
   assign dir_valid      = 1'b0;
`endif

endmodule
